// File: rtl/raisin64_mem_arbiter.sv
// Shared-RAM arbiter for the raisin64 fetch and data ports: one synchronous RAM port,
// programmable wait states, fixed or round-robin priority, one-cycle completion pulses.
module raisin64_mem_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int WAIT_STATES = 0,
    parameter int ARB_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_addr_valid,
    output logic [DATA_WIDTH-1:0] imem_data,
    output logic                  imem_data_valid,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_din,
    output logic [DATA_WIDTH-1:0] dmem_dout,
    input  logic                  dmem_rstrobe,
    input  logic                  dmem_wstrobe,
    output logic                  dmem_cycle_complete,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  grant_dmem;
    logic                  last_grant_dmem;
    logic                  xfer_write;
    logic [DATA_WIDTH-1:0] imem_hold;
    logic [DATA_WIDTH-1:0] dmem_hold;
    logic                  imem_req;
    logic                  dmem_req;
    logic                  pick_valid;
    logic                  pick_dmem;

    assign imem_req = imem_addr_valid;
    assign dmem_req = dmem_rstrobe | dmem_wstrobe;

    // In RESP only the port that was not just served may be picked up back-to-back.
    always_comb begin
        pick_valid = 1'b0;
        pick_dmem  = 1'b0;
        case (state)
            IDLE: begin
                pick_valid = imem_req | dmem_req;
                if (imem_req && dmem_req)
                    pick_dmem = (ARB_MODE == 0) ? 1'b1 : !last_grant_dmem;
                else
                    pick_dmem = dmem_req;
            end
            RESP: begin
                pick_valid = grant_dmem ? imem_req : dmem_req;
                pick_dmem  = !grant_dmem;
            end
            default: begin
                pick_valid = 1'b0;
                pick_dmem  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            wait_cnt            <= '0;
            grant_dmem          <= 1'b0;
            last_grant_dmem     <= 1'b0;
            xfer_write          <= 1'b0;
            ram_cs              <= 1'b0;
            ram_we              <= 1'b0;
            ram_addr            <= '0;
            ram_wdata           <= '0;
            imem_data_valid     <= 1'b0;
            dmem_cycle_complete <= 1'b0;
            imem_hold           <= '0;
            dmem_hold           <= '0;
        end else begin
            imem_data_valid     <= 1'b0;
            dmem_cycle_complete <= 1'b0;

            if (state == ACCESS) begin
                if (wait_cnt == 4'd0) begin
                    state               <= RESP;
                    ram_cs              <= 1'b0;
                    ram_we              <= 1'b0;
                    imem_data_valid     <= !grant_dmem;
                    dmem_cycle_complete <= grant_dmem;
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end

            if (state == RESP && !xfer_write) begin
                if (grant_dmem)
                    dmem_hold <= ram_rdata;
                else
                    imem_hold <= ram_rdata;
            end

            // A write with both strobes high is still a write; it never returns data.
            if (pick_valid) begin
                state           <= ACCESS;
                wait_cnt        <= WAIT_INIT;
                grant_dmem      <= pick_dmem;
                last_grant_dmem <= pick_dmem;
                xfer_write      <= pick_dmem & dmem_wstrobe;
                ram_cs          <= 1'b1;
                ram_we          <= pick_dmem & dmem_wstrobe;
                ram_addr        <= pick_dmem ? dmem_addr : imem_addr;
                if (pick_dmem)
                    ram_wdata <= dmem_din;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end

    assign imem_data = (state == RESP && !grant_dmem) ? ram_rdata : imem_hold;
    assign dmem_dout = (state == RESP && grant_dmem && !xfer_write) ? ram_rdata : dmem_hold;

endmodule

// File: doc/raisin64_mem_arbiter.md
Name: raisin64_mem_arbiter

Overview:
Shared-memory controller between the pipeline's instruction-fetch and data ports and a single synchronous RAM. It replaces the fixed single-cycle dmem handshake and hard-wired imem ready. It arbitrates both requesters onto one RAM port with configurable wait states and arbitration policy. For every transaction it returns a one-cycle completion pulse to the pipeline.

Parameters:
ADDR_WIDTH, 64, width of all address buses
DATA_WIDTH, 64, width of all data buses
WAIT_STATES, 0, extra cycles ram_cs is held per access (0..15)
ARB_MODE, 0, 0 = fixed data-port priority, 1 = round-robin between ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_addr  in  ADDR_WIDTH  fetch address
imem_addr_valid  in  1  fetch request, held until imem_data_valid
imem_data  out  DATA_WIDTH  fetched word
imem_data_valid  out  1  one-cycle fetch-complete pulse
dmem_addr  in  ADDR_WIDTH  data address
dmem_din  in  DATA_WIDTH  write data from pipeline
dmem_dout  out  DATA_WIDTH  read data to pipeline
dmem_rstrobe  in  1  read request, held until complete
dmem_wstrobe  in  1  write request, held until complete
dmem_cycle_complete  out  1  one-cycle data-complete pulse
ram_addr  out  ADDR_WIDTH  RAM address
ram_cs  out  1  RAM select
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a clk edge with ram_cs=1, ram_we=0

Behaviour:
- Reset: the following are all 0.
  - Outputs: ram_cs, ram_we, ram_addr, ram_wdata, imem_data_valid, dmem_cycle_complete, imem_data, dmem_dout.
  - Internal: state=IDLE, wait counter, grant register, last_grant (=imem).
- Reset asserted mid-transaction aborts the transaction immediately. No completion pulse follows.
- States:
  - IDLE: no RAM activity.
  - ACCESS: ram_cs=1 from latched request, counter loaded with WAIT_STATES.
  - RESP: completion pulse; ram_cs=0.
- IDLE -> ACCESS on any eligible request.
  - The winner's address, write data and write flag are latched at that edge.
  - ram_addr/ram_we/ram_wdata come only from the latched values and are stable throughout ACCESS.
- ACCESS: the counter decrements each edge. When it is 0 at an edge, go to RESP.
- RESP -> ACCESS if the other (not just-served) port requests; otherwise RESP -> IDLE.
- The just-served port's request is ignored during its RESP cycle. If it is still asserted the following cycle, that is a new transaction.
- Latency: request first seen at cycle 0 gives a completion pulse in cycle WAIT_STATES+2. The RAM is busy WAIT_STATES+1 cycles.
- Reads:
  - During RESP, imem_data/dmem_dout pass ram_rdata through for the served port.
  - At the end of RESP the value is captured into that port's hold register.
  - The hold register drives the output until the port's next read completes.
- Writes: ram_we=1 in ACCESS. Completion is in RESP; dmem_dout is unchanged.
- dmem_rstrobe and dmem_wstrobe both high: treated as a write, and no read data is returned.
- Arbitration when both ports request in IDLE:
  - ARB_MODE=0: data wins.
  - ARB_MODE=1: the port not equal to last_grant wins.
  - last_grant updates on every grant.
- Deasserting a request before completion is illegal. The transaction still completes, and the pulse is still generated.
- Addresses pass through unmodified; range wrap is the RAM's concern.

Test Plan:
- Read, WAIT_STATES=0: RAM holds 0x1122334455667788 at 0x10; dmem_rstrobe at cycle 0 with addr 0x10 -> ram_cs high in cycle 1, dmem_cycle_complete pulse in cycle 2, dmem_dout=0x1122334455667788 and held afterwards.
- Write then read, WAIT_STATES=3: write 0xDEADBEEF00C0FFEE to 0x20 -> ram_we high exactly 4 cycles, complete in cycle 5; a following read of 0x20 returns 0xDEADBEEF00C0FFEE.
- Contention, ARB_MODE=0: imem (addr 0x0) and dmem read (addr 0x8) both requested at cycle 0 and held -> dmem completes in cycle 2, imem goes directly RESP->ACCESS and completes in cycle 4; the next grant is dmem again if it is still requesting.
- Contention, ARB_MODE=1 with both ports continuously requesting -> grants alternate imem/dmem; there are no idle cycles between transactions and each port completes every 4 cycles at WAIT_STATES=0.
- rstrobe and wstrobe together on addr 0x30 with data 0xA5A5A5A5A5A5A5A5 -> write occurs, dmem_dout keeps its previous value, and a later read of 0x30 returns 0xA5A5A5A5A5A5A5A5.
- rst_n pulsed low in the ACCESS phase of a WAIT_STATES=2 read -> all outputs 0 at once, no completion pulse; the first request after release completes in cycle WAIT_STATES+2.
